// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES datapath types and GF(2^8) helpers.
//
// Contents
//   GF_POLY      low byte of the AES field polynomial x^8+x^4+x^3+x+1
//   byte_t       one state byte
//   word_t       one 32-bit state column, row0 byte in the top byte
//   state_t      full 128-bit state, column i at bits [i*32 +: 32]
//   mc_state_e   MixColumns scheduler FSM encoding
//   xtime        multiply a byte by 2 in GF(2^8)
//   get_byte     pull row r out of a column word
//   get_col      pull column c out of a state
//   put_col      replace column c of a state
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam logic [7:0] GF_POLY = 8'h1B;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  word_t;
    typedef logic [127:0] state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mc_state_e;

    // Doubling in GF(2^8): shift left and fold the overflow bit back in
    // through the reduction polynomial.
    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
    endfunction

    // Row 0 sits in the most significant byte, so the bit offset is
    // (3 - row) * 8, which for a 2-bit row index is simply ~row * 8.
    function automatic byte_t get_byte(input word_t w, input logic [1:0] row);
        return w[{~row, 3'b000} +: 8];
    endfunction

    function automatic word_t get_col(input state_t s, input logic [1:0] col);
        return s[{col, 5'b00000} +: 32];
    endfunction

    function automatic state_t put_col(input state_t s, input logic [1:0] col,
                                       input word_t w);
        state_t r;
        r = s;
        r[{col, 5'b00000} +: 32] = w;
        return r;
    endfunction

endpackage

// File: rtl/mix_column_word.sv
// ---------------------------------------------------------------------------
// mix_column_word
// Purely combinational MixColumns for one 32-bit column, forward or inverse.
//
// Ports
//   col_in   in   32   column bytes a0..a3, a0 in [31:24], a3 in [7:0]
//   inv      in   1    1 = inverse MixColumns, 0 = forward
//   col_out  out  32   mixed column r0..r3, same byte layout as col_in
// ---------------------------------------------------------------------------
module mix_column_word
    import aes_pkg::*;
(
    input  word_t col_in,
    input  logic  inv,
    output word_t col_out
);

    byte_t a  [4];
    byte_t x2 [4];
    byte_t x4 [4];
    byte_t x8 [4];
    byte_t r  [4];

    // Split the column into row bytes and build the doubling chain once per
    // byte; every coefficient needed by either direction is an XOR of these
    // powers of two (3 = 2+1, 9 = 8+1, B = 8+2+1, D = 8+4+1, E = 8+4+2).
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            a[2'(i)]  = get_byte(col_in, 2'(i));
            x2[2'(i)] = xtime(a[2'(i)]);
            x4[2'(i)] = xtime(x2[2'(i)]);
            x8[2'(i)] = xtime(x4[2'(i)]);
        end
    end

    // Both matrices are circulant, so row i uses the same coefficient
    // pattern rotated by i. The 2-bit casts make the rotation wrap mod 4.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            if (inv) begin
                r[2'(i)] = (x8[2'(i)]   ^ x4[2'(i)]   ^ x2[2'(i)])
                         ^ (x8[2'(i+1)] ^ x2[2'(i+1)] ^ a[2'(i+1)])
                         ^ (x8[2'(i+2)] ^ x4[2'(i+2)] ^ a[2'(i+2)])
                         ^ (x8[2'(i+3)] ^ a[2'(i+3)]);
            end else begin
                r[2'(i)] = x2[2'(i)]
                         ^ (x2[2'(i+1)] ^ a[2'(i+1)])
                         ^ a[2'(i+2)]
                         ^ a[2'(i+3)];
            end
        end
    end

    assign col_out = {r[0], r[1], r[2], r[3]};

endmodule

// File: rtl/mix_columns_seq.sv
// ---------------------------------------------------------------------------
// mix_columns_seq
// Column-serial AES MixColumns stage. One 128-bit state is accepted per
// input handshake, its four columns are pushed through COL_LANES shared
// column engines over 4/COL_LANES cycles, and the mixed state is presented
// on a valid/ready output that holds under back-pressure.
//
// Parameters
//   COL_LANES  column engines, 1, 2 or 4
//   EN_INV     1 = inverse MixColumns selectable through inv_in
//   CNT_W      width of the completed-block counter
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      state_in / inv_in valid
//   in_ready   out  1      block idle and able to accept a state
//   state_in   in   128    column i at [i*32 +: 32], row0 byte on top
//   inv_in     in   1      1 = inverse MixColumns for this state
//   out_valid  out  1      state_out valid, held until accepted
//   out_ready  in   1      downstream accepts state_out
//   state_out  out  128    mixed state, same layout as state_in
//   busy       out  1      a state is in flight or awaiting acceptance
//   blk_cnt    out  CNT_W  completed output handshakes, saturating
// ---------------------------------------------------------------------------
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int COL_LANES = 1,
    parameter bit EN_INV    = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     state_in,
    input  logic             inv_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     state_out,
    output logic             busy,
    output logic [CNT_W-1:0] blk_cnt
);

    if (COL_LANES != 1 && COL_LANES != 2 && COL_LANES != 4) begin : g_bad_lanes
        $error("mix_columns_seq: COL_LANES must be 1, 2 or 4");
    end

    // The column index advances by one lane group per RUN cycle. With four
    // lanes the step wraps to zero and the single group is also the last.
    localparam logic [1:0] LANE_STEP = 2'(COL_LANES);
    localparam logic [1:0] LAST_IDX  = 2'(4 - COL_LANES);

    mc_state_e        state;
    mc_state_e        state_next;
    logic [1:0]       col_idx;
    state_t           cap_state;
    logic             cap_inv;
    state_t           out_reg;
    state_t           out_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             accept;

    logic [1:0]       lane_col [COL_LANES];
    word_t            lane_in  [COL_LANES];
    word_t            lane_out [COL_LANES];
    state_t           stage    [COL_LANES+1];

    assign accept = in_valid && in_ready;

    // Each lane works on the column at its fixed offset from the current
    // group index and reads it from the captured input state.
    for (genvar g = 0; g < COL_LANES; g++) begin : g_lane
        assign lane_col[g] = col_idx + 2'(g);
        assign lane_in[g]  = get_col(cap_state, lane_col[g]);

        mix_column_word u_mix (
            .col_in  (lane_in[g]),
            .inv     (cap_inv),
            .col_out (lane_out[g])
        );
    end

    // Merge the lane results into the output register image one lane at a
    // time; columns not covered by this group keep their previous value.
    assign stage[0] = out_reg;
    for (genvar g = 0; g < COL_LANES; g++) begin : g_merge
        assign stage[g+1] = put_col(stage[g], lane_col[g], lane_out[g]);
    end
    assign out_next = stage[COL_LANES];

    // FSM state register; reset abandons any state in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode. The input side is only open in IDLE
    // and the output side only in DONE, so blocks never overlap.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (col_idx == LAST_IDX) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                busy       = 1'b0;
            end
        endcase
    end

    // Capture the input state on acceptance, then walk the column groups
    // while in RUN. Nothing here moves in DONE, which keeps state_out and
    // the captured direction stable for as long as the output is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_state <= '0;
            cap_inv   <= 1'b0;
            col_idx   <= '0;
            out_reg   <= '0;
        end else if (accept) begin
            cap_state <= state_in;
            cap_inv   <= EN_INV ? inv_in : 1'b0;
            col_idx   <= '0;
        end else if (state == ST_RUN) begin
            out_reg   <= out_next;
            col_idx   <= col_idx + LANE_STEP;
        end
    end

    // Completed-block counter, advanced on each output handshake and held
    // at all-ones once it gets there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (out_valid && out_ready && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign state_out = out_reg;
    assign blk_cnt   = cnt_reg;

endmodule

// File: tb/tb_mix_columns_seq.sv
// ---------------------------------------------------------------------------
// tb_mix_columns_seq
// Runs five mix_columns_seq configurations side by side on shared inputs:
//   0: 1 lane, inverse enabled, 16-bit counter
//   1: 2 lanes
//   2: 4 lanes
//   3: 1 lane, inverse disabled
//   4: 1 lane, 2-bit counter
// Expected results are hand-computed AES MixColumns values.
// ---------------------------------------------------------------------------
module tb_mix_columns_seq;
    import aes_pkg::*;

    localparam int N_DUT = 5;

    typedef struct {
        state_t din;
        logic   inv;
        state_t dout;
        state_t dout_fwd_only;
        logic   chk_fwd_only;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        inv_in;
    logic        out_ready;
    state_t      state_in;

    logic        in_ready  [N_DUT];
    logic        out_valid [N_DUT];
    logic        busy      [N_DUT];
    state_t      state_out [N_DUT];
    logic [15:0] cnt16     [4];
    logic [1:0]  cnt2;

    int checks = 0;
    int errors = 0;
    int blocks = 0;

    vec_t vecs [5];

    always #5 clk = ~clk;

    mix_columns_seq #(.COL_LANES(1), .EN_INV(1'b1), .CNT_W(16)) u_l1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
        .state_in(state_in), .inv_in(inv_in), .out_valid(out_valid[0]),
        .out_ready(out_ready), .state_out(state_out[0]), .busy(busy[0]),
        .blk_cnt(cnt16[0]));

    mix_columns_seq #(.COL_LANES(2), .EN_INV(1'b1), .CNT_W(16)) u_l2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
        .state_in(state_in), .inv_in(inv_in), .out_valid(out_valid[1]),
        .out_ready(out_ready), .state_out(state_out[1]), .busy(busy[1]),
        .blk_cnt(cnt16[1]));

    mix_columns_seq #(.COL_LANES(4), .EN_INV(1'b1), .CNT_W(16)) u_l4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]),
        .state_in(state_in), .inv_in(inv_in), .out_valid(out_valid[2]),
        .out_ready(out_ready), .state_out(state_out[2]), .busy(busy[2]),
        .blk_cnt(cnt16[2]));

    mix_columns_seq #(.COL_LANES(1), .EN_INV(1'b0), .CNT_W(16)) u_fwd (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[3]),
        .state_in(state_in), .inv_in(inv_in), .out_valid(out_valid[3]),
        .out_ready(out_ready), .state_out(state_out[3]), .busy(busy[3]),
        .blk_cnt(cnt16[3]));

    mix_columns_seq #(.COL_LANES(1), .EN_INV(1'b1), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[4]),
        .state_in(state_in), .inv_in(inv_in), .out_valid(out_valid[4]),
        .out_ready(out_ready), .state_out(state_out[4]), .busy(busy[4]),
        .blk_cnt(cnt2));

    // Cycles from input handshake to out_valid for each configuration.
    function automatic int lat_of(input int k);
        case (k)
            1:       return 2;
            2:       return 1;
            default: return 4;
        endcase
    endfunction

    // Expected counter value after n completed blocks.
    function automatic logic [15:0] exp_cnt(input int k, input int n);
        if (k == 4) begin
            return (n > 3) ? 16'd3 : 16'(n);
        end
        return 16'(n);
    endfunction

    function automatic logic [15:0] act_cnt(input int k);
        if (k == 4) begin
            return {14'd0, cnt2};
        end
        return cnt16[k];
    endfunction

    task automatic check_output(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        for (int k = 0; k < N_DUT; k++) begin
            check_output($sformatf("%s in_ready[%0d]", tag, k), 128'(in_ready[k]), 128'd1);
            check_output($sformatf("%s out_valid[%0d]", tag, k), 128'(out_valid[k]), 128'd0);
            check_output($sformatf("%s busy[%0d]", tag, k), 128'(busy[k]), 128'd0);
            check_output($sformatf("%s state_out[%0d]", tag, k), state_out[k], 128'd0);
            check_output($sformatf("%s blk_cnt[%0d]", tag, k), 128'(act_cnt(k)), 128'd0);
        end
    endtask

    function automatic state_t exp_out(input int k, input vec_t v);
        return (k == 3) ? v.dout_fwd_only : v.dout;
    endfunction

    // One block with out_ready held high; called and returns at a negedge
    // with every instance idle.
    task automatic apply_stimulus(input vec_t v, input string tag);
        for (int k = 0; k < N_DUT; k++) begin
            check_output($sformatf("%s idle in_ready[%0d]", tag, k), 128'(in_ready[k]), 128'd1);
        end
        state_in = v.din;
        inv_in   = v.inv;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        state_in = ~v.din;
        inv_in   = ~v.inv;
        for (int k = 0; k < N_DUT; k++) begin
            check_output($sformatf("%s busy[%0d]", tag, k), 128'(busy[k]), 128'd1);
        end
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            for (int k = 0; k < N_DUT; k++) begin
                check_output($sformatf("%s c%0d out_valid[%0d]", tag, c, k),
                             128'(out_valid[k]), 128'(c == lat_of(k)));
                if (c == lat_of(k) && (k != 3 || v.chk_fwd_only)) begin
                    check_output($sformatf("%s state_out[%0d]", tag, k),
                                 state_out[k], exp_out(k, v));
                end
            end
        end
        blocks++;
        for (int k = 0; k < N_DUT; k++) begin
            check_output($sformatf("%s blk_cnt[%0d]", tag, k), 128'(act_cnt(k)),
                         128'(exp_cnt(k, blocks)));
        end
    endtask

    initial begin
        vecs[0] = '{din: {4{32'hdb135345}}, inv: 1'b0,
                    dout: {4{32'h8e4da1bc}}, dout_fwd_only: {4{32'h8e4da1bc}},
                    chk_fwd_only: 1'b1};
        vecs[1] = '{din: {32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'hd4d4d4d5}, inv: 1'b0,
                    dout: {32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'hd5d5d7d6},
                    dout_fwd_only: {32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'hd5d5d7d6},
                    chk_fwd_only: 1'b1};
        vecs[2] = '{din: {32'h1e2798e5, 32'hb84111f1, 32'he0b452ae, 32'hd4bf5d30}, inv: 1'b0,
                    dout: {32'h2806264c, 32'h48f8d37a, 32'he0cb199a, 32'h046681e5},
                    dout_fwd_only: {32'h2806264c, 32'h48f8d37a, 32'he0cb199a, 32'h046681e5},
                    chk_fwd_only: 1'b1};
        vecs[3] = '{din: {4{32'h8e4da1bc}}, inv: 1'b1,
                    dout: {4{32'hdb135345}}, dout_fwd_only: {4{32'hcd504506}},
                    chk_fwd_only: 1'b1};
        vecs[4] = '{din: {32'h2806264c, 32'h48f8d37a, 32'he0cb199a, 32'h046681e5}, inv: 1'b1,
                    dout: {32'h1e2798e5, 32'hb84111f1, 32'he0b452ae, 32'hd4bf5d30},
                    dout_fwd_only: '0, chk_fwd_only: 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        inv_in    = 1'b0;
        out_ready = 1'b1;
        state_in  = '0;
        #1;
        check_reset("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Table vectors, back to back; also walks the 2-bit counter to saturation.
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-pressure: output held for 10 cycles while a new input waits.
        out_ready = 1'b0;
        state_in  = vecs[2].din;
        inv_in    = 1'b0;
        in_valid  = 1'b1;
        @(negedge clk);
        state_in = vecs[0].din;
        inv_in   = 1'b1;
        repeat (4) @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            for (int k = 0; k < N_DUT; k++) begin
                check_output($sformatf("bp%0d out_valid[%0d]", c, k), 128'(out_valid[k]), 128'd1);
                check_output($sformatf("bp%0d state_out[%0d]", c, k), state_out[k], vecs[2].dout);
                check_output($sformatf("bp%0d in_ready[%0d]", c, k), 128'(in_ready[k]), 128'd0);
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        blocks++;
        for (int k = 0; k < N_DUT; k++) begin
            check_output($sformatf("bp release in_ready[%0d]", k), 128'(in_ready[k]), 128'd1);
            check_output($sformatf("bp release out_valid[%0d]", k), 128'(out_valid[k]), 128'd0);
            check_output($sformatf("bp release blk_cnt[%0d]", k), 128'(act_cnt(k)),
                         128'(exp_cnt(k, blocks)));
        end

        // Reset while the single-lane engines are at column 2.
        state_in = vecs[1].din;
        inv_in   = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset("midrun reset");
        blocks = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            for (int k = 0; k < N_DUT; k++) begin
                check_output($sformatf("post reset%0d out_valid[%0d]", c, k), 128'(out_valid[k]), 128'd0);
                check_output($sformatf("post reset%0d busy[%0d]", c, k), 128'(busy[k]), 128'd0);
            end
        end
        apply_stimulus(vecs[3], "after reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
